// File: rtl/forwarding_scoreboard.sv
`default_nettype none
// forwarding_scoreboard: decode-stage hazard scoreboard that resolves forwarding in ID,
// registers per-operand forward selects into EX and stalls until a needed result is forwardable.
module forwarding_scoreboard #(
  parameter  int DEPTH  = 2,
  parameter  int REG_AW = 5,
  parameter  int AVL_W  = 2,
  parameter  int CNT_W  = 32,
  localparam int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_freeze,
  input  logic              i_flush,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_id_rd_addr,
  input  logic              i_id_reg_write,
  input  logic [AVL_W-1:0]  i_id_avail,
  output logic              o_stall,
  output logic [SEL_W-1:0]  o_ex_fwd_a,
  output logic [SEL_W-1:0]  o_ex_fwd_b,
  output logic [CNT_W-1:0]  o_stall_cycles
);

  // Position p holds the writer p stages past the ID/EX boundary (p = 0 is in EX).
  logic              rec_valid [DEPTH];
  logic [REG_AW-1:0] rec_rd    [DEPTH];
  logic              rec_wen   [DEPTH];
  logic [SEL_W-1:0]  rec_av    [DEPTH];

  logic [SEL_W-1:0]  sel_a, sel_b;
  logic              haz_a, haz_b;
  logic [SEL_W-1:0]  avail_clamped;
  logic              issue;
  logic              count_en;

  // Returns {hazard, select}; scanning oldest to youngest lets the youngest match win.
  function automatic logic [SEL_W:0] lookup(input logic [REG_AW-1:0] rs, input logic used);
    logic [SEL_W-1:0] sel;
    logic             haz;
    sel = '0;
    haz = 1'b0;
    if (used && (rs != '0)) begin
      for (int p = DEPTH - 1; p >= 0; p--) begin
        if (rec_valid[p] && rec_wen[p] && (rec_rd[p] == rs)) begin
          sel = SEL_W'(p + 1);
          haz = (rec_av[p] > SEL_W'(p + 1));
        end
      end
    end
    return {haz, sel};
  endfunction

  always_comb begin
    {haz_a, sel_a} = lookup(i_id_rs1_addr, i_id_rs1_used);
    {haz_b, sel_b} = lookup(i_id_rs2_addr, i_id_rs2_used);
  end

  always_comb begin
    if (i_id_avail == '0) begin
      avail_clamped = SEL_W'(1);
    end else if (32'(i_id_avail) > 32'(DEPTH)) begin
      avail_clamped = SEL_W'(DEPTH);
    end else begin
      avail_clamped = SEL_W'(i_id_avail);
    end
  end

  assign o_stall  = i_id_valid & ~i_flush & (haz_a | haz_b);
  assign issue    = i_id_valid & ~o_stall & ~i_flush & ~i_freeze;
  assign count_en = i_id_valid & o_stall & ~i_flush & ~i_freeze;

  // The oldest record simply falls off: it is written to the write-through register file this edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int p = 0; p < DEPTH; p++) begin
        rec_valid[p] <= 1'b0;
        rec_rd[p]    <= '0;
        rec_wen[p]   <= 1'b0;
        rec_av[p]    <= '0;
      end
    end else if (!i_freeze) begin
      for (int p = DEPTH - 1; p > 0; p--) begin
        rec_valid[p] <= rec_valid[p-1];
        rec_rd[p]    <= rec_rd[p-1];
        rec_wen[p]   <= rec_wen[p-1];
        rec_av[p]    <= rec_av[p-1];
      end
      rec_valid[0] <= issue;
      rec_rd[0]    <= issue ? i_id_rd_addr : '0;
      rec_wen[0]   <= issue & i_id_reg_write & (i_id_rd_addr != '0);
      rec_av[0]    <= issue ? avail_clamped : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ex_fwd_a <= '0;
      o_ex_fwd_b <= '0;
    end else if (!i_freeze) begin
      o_ex_fwd_a <= issue ? sel_a : '0;
      o_ex_fwd_b <= issue ? sel_b : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cycles <= '0;
    end else if (count_en && (o_stall_cycles != '1)) begin
      o_stall_cycles <= o_stall_cycles + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
